writeback_queue: RTL and testbench

Write-back side driver for the register file. Collects results from the ALU path and the memory-load path into a small ordered queue and issues at most one register write per cycle on the register file's write port (`writeBackEn`, `Dest_wb`, `Result_WB`). Also reports pending-write hazards for the decode stage's two source registers. Sits between the EX/MEM pipeline registers and the register file.

---
 rtl/writeback_queue.sv | 180 ++++++++++++++++++
 tb/tb_writeback_queue.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/writeback_queue.sv
// -----------------------------------------------------------------------------
// writeback_queue
//
// Write-back driver for the register file. Results from the memory-load path
// (older) and the ALU path (younger) are collected into a small in-order FIFO.
// At most one register write is issued per cycle through registered outputs
// that change only on posedge. The register file samples them on negedge.
// Pending writes are reported as hazards against the two decode-stage source
// registers.
//
// Optional feature: define WBQ_BYPASS_EN so that, with an empty queue, the
// oldest accepted input goes straight into the output registers. This saves
// one cycle of latency.
//
// Parameters
//   WORD_SIZE     data width
//   ADDRESS_SIZE  register index width
//   DEPTH         queue entries (power of two, >= 2)
//
// Ports
//   clk, rst                 clock (posedge), asynchronous active-low reset
//   mem_valid/dest/result    load result (older of the two inputs)
//   alu_valid/dest/result    ALU result (younger of the two inputs)
//   src1, src2               decode-stage source register indices
//   writeBackEn              register write strobe
//   Dest_wb, Result_WB       register write index and data
//   stall                    fewer than two free slots; producers must hold
//   hazard1, hazard2         a write to src1 / src2 is still pending
//   overflow                 sticky: an input was dropped
// -----------------------------------------------------------------------------
module writeback_queue #(
    parameter int WORD_SIZE    = 32,
    parameter int ADDRESS_SIZE = 4,
    parameter int DEPTH        = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    mem_valid,
    input  logic [ADDRESS_SIZE-1:0] mem_dest,
    input  logic [WORD_SIZE-1:0]    mem_result,
    input  logic                    alu_valid,
    input  logic [ADDRESS_SIZE-1:0] alu_dest,
    input  logic [WORD_SIZE-1:0]    alu_result,
    input  logic [ADDRESS_SIZE-1:0] src1,
    input  logic [ADDRESS_SIZE-1:0] src2,
    output logic                    writeBackEn,
    output logic [ADDRESS_SIZE-1:0] Dest_wb,
    output logic [WORD_SIZE-1:0]    Result_WB,
    output logic                    stall,
    output logic                    hazard1,
    output logic                    hazard2,
    output logic                    overflow
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_C   = CW'(DEPTH);
    localparam logic [CW-1:0] ALMOST_C = CW'(DEPTH - 1);

    logic [ADDRESS_SIZE-1:0] dest_mem [DEPTH];
    logic [WORD_SIZE-1:0]    data_mem [DEPTH];
    logic [PW-1:0]           rd_ptr, wr_ptr;
    logic [CW-1:0]           count;

    logic                    mem_ok, alu_ok;
    logic                    first_v, second_v;
    logic [ADDRESS_SIZE-1:0] first_dest;
    logic [WORD_SIZE-1:0]    first_data;
    logic                    pop, byp;
    logic                    en_a, en_b, drop;
    logic [ADDRESS_SIZE-1:0] a_dest;
    logic [WORD_SIZE-1:0]    a_data;
    logic [CW-1:0]           count_next;

    // Writes to R0 are discarded up front and take no slot.
    assign mem_ok = mem_valid && (mem_dest != '0);
    assign alu_ok = alu_valid && (alu_dest != '0);

    // The oldest accepted input is mem when present, otherwise alu. A second
    // candidate exists only when both are present, and it is always alu.
    assign first_v    = mem_ok || alu_ok;
    assign first_dest = mem_ok ? mem_dest   : alu_dest;
    assign first_data = mem_ok ? mem_result : alu_result;
    assign second_v   = mem_ok && alu_ok;

    assign pop = (count != '0);

`ifdef WBQ_BYPASS_EN
    assign byp = (count == '0) && first_v;
`else
    assign byp = 1'b0;
`endif

    // NOTE: every signal written in always_comb gets a default value first, so
    // no path through the block leaves it unassigned. That would infer a latch.
    always_comb begin
        en_a   = 1'b0;
        en_b   = 1'b0;
        a_dest = first_dest;
        a_data = first_data;
        if (byp) begin
            // The first input goes to the output registers. A second input
            // takes slot A of the (empty) queue.
            en_a   = second_v;
            a_dest = alu_dest;
            a_data = alu_result;
        end else begin
            // Capacity is judged on occupancy before this cycle's pop.
            en_a = first_v  && (count < FULL_C);
            en_b = second_v && (count < ALMOST_C);
        end
        drop       = !byp && ((first_v && !en_a) || (second_v && !en_b));
        count_next = count + CW'(en_a) + CW'(en_b) - CW'(pop);
    end

    assign stall = (count >= ALMOST_C);

    // A source register is hazarded by any occupied entry, and also by the
    // write currently on the output port.
    always_comb begin
        logic [PW-1:0] idx;
        hazard1 = 1'b0;
        hazard2 = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = rd_ptr + PW'(i);
            if (CW'(i) < count) begin
                if (dest_mem[idx] == src1) hazard1 = 1'b1;
                if (dest_mem[idx] == src2) hazard2 = 1'b1;
            end
        end
        if (writeBackEn && (Dest_wb == src1)) hazard1 = 1'b1;
        if (writeBackEn && (Dest_wb == src2)) hazard2 = 1'b1;
        if (src1 == '0) hazard1 = 1'b0;
        if (src2 == '0) hazard2 = 1'b0;
    end

    // NOTE: state registers use non-blocking assignments, so every flop
    // samples its inputs from before the edge, whatever the statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
            writeBackEn <= 1'b0;
            Dest_wb     <= '0;
            Result_WB   <= '0;
            overflow    <= 1'b0;
        end else begin
            if (pop) begin
                writeBackEn <= 1'b1;
                Dest_wb     <= dest_mem[rd_ptr];
                Result_WB   <= data_mem[rd_ptr];
                rd_ptr      <= rd_ptr + 1'b1;
            end else if (byp) begin
                writeBackEn <= 1'b1;
                Dest_wb     <= first_dest;
                Result_WB   <= first_data;
            end else begin
                writeBackEn <= 1'b0;
            end
            wr_ptr <= wr_ptr + PW'(en_a) + PW'(en_b);
            count  <= count_next;
            if (drop) overflow <= 1'b1;
        end
    end

    // NOTE: the storage array has no reset. Occupancy comes only from count,
    // so stale contents are never observed, and a plain RAM can be used.
    always_ff @(posedge clk) begin
        if (en_a) begin
            dest_mem[wr_ptr] <= a_dest;
            data_mem[wr_ptr] <= a_data;
        end
        if (en_b) begin
            dest_mem[wr_ptr + 1'b1] <= alu_dest;
            data_mem[wr_ptr + 1'b1] <= alu_result;
        end
    end

endmodule

// File: tb/tb_writeback_queue.sv
// -----------------------------------------------------------------------------
// tb_writeback_queue
//
// Self-checking bench for writeback_queue. Directed stimulus pushes the
// hand-computed register writes into a scoreboard queue. A monitor on negedge
// pops an entry and compares it whenever writeBackEn is high. Directed checks
// cover latency, stall, overflow, hazards and reset.
// -----------------------------------------------------------------------------
module tb_writeback_queue;

`ifdef WBQ_BYPASS_EN
    localparam logic BYP = 1'b1;
`else
    localparam logic BYP = 1'b0;
`endif

    typedef struct packed {
        logic [3:0]  dest;
        logic [31:0] data;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_valid = 1'b0, alu_valid = 1'b0;
    logic [3:0]  mem_dest = '0, alu_dest = '0, src1 = '0, src2 = '0;
    logic [31:0] mem_result = '0, alu_result = '0;
    logic        writeBackEn, stall, hazard1, hazard2, overflow;
    logic [3:0]  Dest_wb;
    logic [31:0] Result_WB;

    int  n_tests = 0;
    int  n_fail  = 0;
    wr_t sb[$];

    writeback_queue #(.WORD_SIZE(32), .ADDRESS_SIZE(4), .DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .mem_valid(mem_valid), .mem_dest(mem_dest), .mem_result(mem_result),
        .alu_valid(alu_valid), .alu_dest(alu_dest), .alu_result(alu_result),
        .src1(src1), .src2(src2),
        .writeBackEn(writeBackEn), .Dest_wb(Dest_wb), .Result_WB(Result_WB),
        .stall(stall), .hazard1(hazard1), .hazard2(hazard2), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic expect_wr(input logic [3:0] d, input logic [31:0] v);
        sb.push_back('{dest: d, data: v});
    endtask

    // The inputs are applied at negedge and held across one posedge. The task
    // returns 1 time unit after that posedge, with the valids cleared.
    task automatic drive(input logic mv, input logic [3:0] md, input logic [31:0] mr,
                         input logic av, input logic [3:0] ad, input logic [31:0] ar);
        @(negedge clk);
        mem_valid = mv; mem_dest = md; mem_result = mr;
        alu_valid = av; alu_dest = ad; alu_result = ar;
        @(posedge clk);
        #1;
        mem_valid = 1'b0;
        alu_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        if (rst && writeBackEn) begin
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL spurious_wb: got write R%0d=%h, expected no write", Dest_wb, Result_WB);
            end else begin
                wr_t e;
                e = sb.pop_front();
                check("wb_dest", {28'd0, Dest_wb}, {28'd0, e.dest});
                check("wb_data", Result_WB, e.data);
            end
        end
    end

    initial begin
        int pulses;

        // Reset state
        #2 rst = 1'b0;
        #1;
        check("rst_wben",   {31'd0, writeBackEn}, 32'd0);
        check("rst_dest",   {28'd0, Dest_wb},     32'd0);
        check("rst_result", Result_WB,            32'd0);
        check("rst_stall",  {31'd0, stall},       32'd0);
        check("rst_ovf",    {31'd0, overflow},    32'd0);
        check("rst_hz",     {30'd0, hazard1, hazard2}, 32'd0);
        idle(2);
        @(negedge clk) rst = 1'b1;
        idle(2);

        // Ordering and latency: mem R3 comes before alu R5
        expect_wr(4'd3, 32'hAAAA);
        expect_wr(4'd5, 32'h5555);
        drive(1'b1, 4'd3, 32'hAAAA, 1'b1, 4'd5, 32'h5555);
        check("lat_edge_n", {31'd0, writeBackEn}, {31'd0, BYP});
        if (!BYP) idle(1);
        check("ord_first_en",   {31'd0, writeBackEn}, 32'd1);
        check("ord_first_dest", {28'd0, Dest_wb},     32'd3);
        idle(1);
        check("ord_second_en",   {31'd0, writeBackEn}, 32'd1);
        check("ord_second_dest", {28'd0, Dest_wb},     32'd5);
        idle(1);
        check("ord_done_en", {31'd0, writeBackEn}, 32'd0);
        idle(2);

        // R0 filter
        src1 = 4'd0;
        drive(1'b0, 4'd0, 32'h0, 1'b1, 4'd0, 32'h1234);
        check("r0_en_n",  {31'd0, writeBackEn}, 32'd0);
        check("r0_stall", {31'd0, stall},       32'd0);
        check("r0_hz1",   {31'd0, hazard1},     32'd0);
        idle(1);
        check("r0_en_n1", {31'd0, writeBackEn}, 32'd0);
        check("r0_hz1_n1", {31'd0, hazard1},    32'd0);
        expect_wr(4'd2, 32'h22);
        drive(1'b1, 4'd0, 32'hDEAD, 1'b1, 4'd2, 32'h22);
        idle(3);

        // Full / stall / overflow via back-to-back dual inputs
        expect_wr(4'd1, 32'h11); expect_wr(4'd2, 32'h22);
        drive(1'b1, 4'd1, 32'h11, 1'b1, 4'd2, 32'h22);
        check("full_a_stall", {31'd0, stall}, 32'd0);
        expect_wr(4'd3, 32'h33); expect_wr(4'd4, 32'h44);
        drive(1'b1, 4'd3, 32'h33, 1'b1, 4'd4, 32'h44);
        check("full_b_stall", {31'd0, stall}, {31'd0, !BYP});
        expect_wr(4'd5, 32'h55);
        if (BYP) expect_wr(4'd6, 32'h66);
        drive(1'b1, 4'd5, 32'h55, 1'b1, 4'd6, 32'h66);
        check("full_c_stall", {31'd0, stall},    32'd1);
        check("full_c_ovf",   {31'd0, overflow}, {31'd0, !BYP});
        expect_wr(4'd7, 32'h77);
        drive(1'b1, 4'd7, 32'h77, 1'b1, 4'd8, 32'h88);
        check("full_d_stall", {31'd0, stall},    32'd1);
        check("full_d_ovf",   {31'd0, overflow}, 32'd1);
        idle(6);
        check("full_drained_stall", {31'd0, stall},    32'd0);
        check("ovf_sticky",         {31'd0, overflow}, 32'd1);

        // Wrap-around: R1..R10 with data equal to the index
        for (int i = 1; i <= 10; i++) begin
            expect_wr(4'(i), 32'(i));
            drive(1'b0, 4'd0, 32'h0, 1'b1, 4'(i), 32'(i));
        end
        idle(4);

        // Hazard on R7
        src1 = 4'd3;
        src2 = 4'd7;
        expect_wr(4'd7, 32'h77);
        drive(1'b1, 4'd7, 32'h77, 1'b0, 4'd0, 32'h0);
        check("hz2_n0", {31'd0, hazard2}, 32'd1);
        check("hz1_n0", {31'd0, hazard1}, 32'd0);
        idle(1);
        check("hz2_n1", {31'd0, hazard2}, {31'd0, !BYP});
        idle(1);
        check("hz2_n2", {31'd0, hazard2}, 32'd0);
        idle(2);

        // Reset mid-burst with entries queued
        src2 = 4'd3;
        expect_wr(4'd1, 32'h11); expect_wr(4'd2, 32'h22);
        drive(1'b1, 4'd1, 32'h11, 1'b1, 4'd2, 32'h22);
        expect_wr(4'd3, 32'h33); expect_wr(4'd4, 32'h44);
        drive(1'b1, 4'd3, 32'h33, 1'b1, 4'd4, 32'h44);
        check("pre_rst_hz2",  {31'd0, hazard2},     32'd1);
        check("pre_rst_wben", {31'd0, writeBackEn}, 32'd1);
        #2 rst = 1'b0;
        #1;
        sb.delete();
        check("mid_rst_wben",   {31'd0, writeBackEn}, 32'd0);
        check("mid_rst_dest",   {28'd0, Dest_wb},     32'd0);
        check("mid_rst_result", Result_WB,            32'd0);
        check("mid_rst_stall",  {31'd0, stall},       32'd0);
        check("mid_rst_ovf",    {31'd0, overflow},    32'd0);
        check("mid_rst_hz2",    {31'd0, hazard2},     32'd0);
        idle(2);
        @(negedge clk) rst = 1'b1;
        pulses = 0;
        repeat (6) begin
            @(negedge clk);
            if (writeBackEn) pulses++;
        end
        check("post_rst_pulses", 32'(pulses), 32'd0);

        idle(2);
        check("sb_empty", 32'(sb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
